nios_div_cell: RTL

- Iterative radix-2 non-restoring integer divider for the Nios II execute path. It is the inverse-operation companion to the pipelined multiply cell.
- Accepts two source operands at issue and produces quotient and remainder after a fixed multi-cycle latency. It supports signed and unsigned division.
- Sits beside the multiplier in the E/M stages. The CPU stall logic holds the pipeline while busy is high.

---
 rtl/nios_div_cell.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/nios_div_cell.sv
// nios_div_cell: iterative radix-2 non-restoring integer divider for the Nios II
// execute path. One quotient bit per cycle, signed or unsigned operands.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - synchronous active-high reset
//   E_src1   - dividend, sampled on acceptance
//   E_src2   - divisor, sampled on acceptance
//   E_start  - issue strobe, accepted only while idle and not busy
//   E_signed - 1 = two's-complement operands, 0 = unsigned
//   busy     - high from the cycle after acceptance through the done cycle
//   done     - single-cycle pulse, results valid
//   M_quot   - quotient, truncated toward zero
//   M_rem    - remainder, sign of dividend
//   M_dbz    - divisor was zero
module nios_div_cell #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_start,
  input  logic             E_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] M_quot,
  output logic [WIDTH-1:0] M_rem,
  output logic             M_dbz
);

  typedef enum logic [2:0] {StIdle, StPrep, StDiv, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH:0]   pr_q, pr_d;       // partial remainder, two's complement
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] m_quot_q, m_quot_d;
  logic [WIDTH-1:0] m_rem_q, m_rem_d;
  logic             m_dbz_q, m_dbz_d;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_fix;

  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    signed_d = signed_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    pr_d     = pr_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    m_quot_d = m_quot_q;
    m_rem_d  = m_rem_q;
    m_dbz_d  = m_dbz_q;
    shifted  = '0;
    rem_fix  = '0;

    // busy_q stays high through the done cycle, so a start in that cycle is ignored.
    accept = (state_q == StIdle) && E_start && !busy_q;
    done_d = (state_q == StDone);
    busy_d = busy_q;
    if (done_q) busy_d = 1'b0;
    if (accept) busy_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (accept) begin
          src1_d   = E_src1;
          src2_d   = E_src2;
          signed_d = E_signed;
          state_d  = StPrep;
        end
      end
      StPrep: begin
        // Negating the minimum value yields itself, which read unsigned is 2^(WIDTH-1).
        quo_d   = (signed_q && src1_q[WIDTH-1]) ? -src1_q : src1_q;
        dvs_d   = (signed_q && src2_q[WIDTH-1]) ? -src2_q : src2_q;
        qneg_d  = signed_q & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
        rneg_d  = signed_q & src1_q[WIDTH-1];
        dbz_d   = (src2_q == '0);
        pr_d    = '0;
        cnt_d   = CNT_W'(WIDTH);
        state_d = (src2_q == '0) ? StFix : StDiv;
      end
      StDiv: begin
        // pr stays within [-dvs, dvs), so modular WIDTH+1 bit arithmetic is exact.
        shifted = {pr_q[WIDTH-1:0], quo_q[WIDTH-1]};
        pr_d    = pr_q[WIDTH] ? shifted + {1'b0, dvs_q} : shifted - {1'b0, dvs_q};
        quo_d   = {quo_q[WIDTH-2:0], ~pr_d[WIDTH]};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        rem_fix = pr_q[WIDTH] ? pr_q + {1'b0, dvs_q} : pr_q;
        if (dbz_q) begin
          m_quot_d = '1;
          m_rem_d  = src1_q;
          m_dbz_d  = 1'b1;
        end else begin
          m_quot_d = qneg_q ? -quo_q : quo_q;
          m_rem_d  = rneg_q ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
          m_dbz_d  = 1'b0;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      src1_q   <= '0;
      src2_q   <= '0;
      signed_q <= 1'b0;
      quo_q    <= '0;
      dvs_q    <= '0;
      pr_q     <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      m_quot_q <= '0;
      m_rem_q  <= '0;
      m_dbz_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      signed_q <= signed_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      pr_q     <= pr_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      m_quot_q <= m_quot_d;
      m_rem_q  <= m_rem_d;
      m_dbz_q  <= m_dbz_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign M_quot = m_quot_q;
  assign M_rem  = m_rem_q;
  assign M_dbz  = m_dbz_q;

endmodule
